// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// Shifts the BCD digits right into a binary accumulator, one bit per CONV cycle.
module bcd2bin #(
  parameter int unsigned NDIG = 3,
  parameter int unsigned NBIN = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd,
  output logic [NBIN-1:0]   bin,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DW   = 4 * NDIG;
  localparam int unsigned SW   = DW + NBIN;
  localparam int unsigned CW   = 4;
  localparam int unsigned LAST = NBIN - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_step;
  logic [CW-1:0]   cnt;
  logic            bad;
  logic            last;

  assign last = (cnt == CW'(LAST));

  // Any digit above 9 on the input bus makes the request invalid
  always_comb begin
    bad = 1'b0;
    for (int d = 0; d < int'(NDIG); d++) begin
      if (bcd[4*d +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // One conversion step: shift right, then correct every digit field >= 8
  always_comb begin
    sr_step = sr >> 1;
    for (int d = 0; d < int'(NDIG); d++) begin
      if (sr_step[NBIN + 4*d +: 4] >= 4'd8)
        sr_step[NBIN + 4*d +: 4] = sr_step[NBIN + 4*d +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bad ? DONE : CONV;
      CONV:    if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      bin  <= '0;
      err  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == CONV);
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            sr  <= {bcd, NBIN'(0)};
            cnt <= '0;
            err <= bad;
            if (bad) bin <= '0;
          end
        end
        CONV: begin
          sr  <= sr_step;
          cnt <= cnt + CW'(1);
          if (last) bin <= sr_step[NBIN-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed scenarios, random codes and a full
// sweep, all compared against a decimal-arithmetic reference.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd2bin #(.NDIG(3), .NBIN(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_valid(input logic [11:0] b);
    return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int ref_value(input logic [11:0] b);
    return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion from IDLE; optionally hammer start/bcd while busy
  task automatic convert(input logic [11:0] v, input bit disturb);
    bit ok;
    int expv;
    ok   = ref_valid(v);
    expv = ok ? ref_value(v) : 0;
    bcd   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        check("busy_conv", busy, 1);
        check("done_early", done, 0);
        if (disturb) begin
          start = 1'($urandom_range(0, 1));
          bcd   = 12'h777;
        end
        tick();
      end
    end else begin
      check("busy_inv", busy, 0);
    end
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("bin", bin, expv);
    check("err", err, ok ? 0 : 1);
    if (disturb) start = 1'b1;
    tick();
    check("done_drop", done, 0);
    check("busy_idle", busy, 0);
    check("bin_hold", bin, expv);
    check("err_hold", err, ok ? 0 : 1);
    if (disturb) begin
      start = 1'b0;
      tick();
      check("no_queue_busy", busy, 0);
      check("no_queue_done", done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = '0;
    tick();
    tick();
    check("rst_bin", bin, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    convert(12'h255, 1'b0);
    convert(12'h999, 1'b0);
    convert(12'h000, 1'b0);
    convert(12'h1A3, 1'b0);
    convert(12'h042, 1'b0);
    convert(12'hF00, 1'b0);
    convert(12'h123, 1'b1);

    // Reset in the middle of a conversion, then restart immediately
    bcd   = 12'h654;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_bin", bin, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    rst_n = 1'b1;
    convert(12'h128, 1'b0);

    // Random codes, including non-BCD digits
    for (int i = 0; i < 40; i++) begin
      logic [11:0] r;
      r = 12'($urandom);
      if (i % 4 != 0) r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      convert(r, (i % 5 == 0));
    end

    // Back-to-back sweep of every valid code, 12 cycles apart
    for (int h = 0; h < 10; h++)
      for (int t = 0; t < 10; t++)
        for (int u = 0; u < 10; u++)
          convert({4'(h), 4'(t), 4'(u)}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
